// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd
//   Single-clock 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset core with hazard
//   interlocks, operand forwarding, branch flush and synchronous reset.
//   Reg[0:31] and Mem[0:MEM_DEPTH-1] are plain arrays so that programs and
//   register images can be loaded hierarchically while rst is held.
// Ports
//   clk1        single clock, all state updates on posedge
//   rst         synchronous active-high reset (Reg/Mem keep their contents)
//   halted      HLT has retired; core frozen until rst
//   pc_out      current fetch PC (word address)
//   retired_cnt instructions retired in WB (bubbles/flushed slots excluded)
//   stall_cnt   cycles in which IF/ID was held by a hazard interlock
//   dbg_raddr   debug register-read address
//   dbg_rdata   Reg[dbg_raddr], combinational (R0 reads 0)
// Handshake: none; the core is free-running and every stage advances each
//   cycle unless IF/ID is held (stall) or slots are flushed (taken branch).
module pipe_mips32_fwd #(
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int FORWARD_EN = 1
) (
    input  logic              clk1,
    input  logic              rst,
    output logic              halted,
    output logic [31:0]       pc_out,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int MEM_W = (DATA_W > 32) ? DATA_W : 32;

    localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND   = 6'h02, OP_OR   = 6'h03,
                           OP_SLT  = 6'h04, OP_MUL  = 6'h05, OP_LW    = 6'h08, OP_SW   = 6'h09,
                           OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI  = 6'h0C,
                           OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E, OP_HLT  = 6'h3F;

    logic [DATA_W-1:0] Reg [0:31];
    logic [MEM_W-1:0]  Mem [0:MEM_DEPTH-1];

    // Set once HLT has moved past ID: no further fetches until reset.
    logic              fetch_stop;

    logic              ifid_v;
    logic [31:0]       ifid_ir, ifid_pc;

    logic              idex_v, idex_wr;
    logic [5:0]        idex_op;
    logic [4:0]        idex_rs, idex_rt, idex_dest;
    logic [DATA_W-1:0] idex_a, idex_b;
    logic [15:0]       idex_imm;
    logic [31:0]       idex_pc;

    logic              exmem_v, exmem_wr;
    logic [5:0]        exmem_op;
    logic [4:0]        exmem_dest;
    logic [DATA_W-1:0] exmem_res, exmem_sdata;

    logic              memwb_v, memwb_wr;
    logic [5:0]        memwb_op;
    logic [4:0]        memwb_dest;
    logic [DATA_W-1:0] memwb_res;

    // ---------------- ID: decode, register read, hazard detection ----------------
    logic [5:0]        id_op;
    logic [4:0]        id_rs, id_rt, id_rd, id_dest;
    logic              id_rd_rs, id_rd_rt, id_wr, id_hlt;
    logic [DATA_W-1:0] id_a, id_b;
    logic              wb_hit, hit_ex, hit_mem, stall;

    assign id_op  = ifid_ir[31:26];
    assign id_rs  = ifid_ir[25:21];
    assign id_rt  = ifid_ir[20:16];
    assign id_rd  = ifid_ir[15:11];
    assign id_hlt = ifid_v && (id_op == OP_HLT);

    always_comb begin
        id_rd_rs = 1'b0;
        id_rd_rt = 1'b0;
        id_wr    = 1'b0;
        id_dest  = id_rd;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_rd_rs = 1'b1; id_rd_rt = 1'b1; id_wr = 1'b1; id_dest = id_rd;
            end
            OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
                id_rd_rs = 1'b1; id_wr = 1'b1; id_dest = id_rt;
            end
            OP_SW: begin
                id_rd_rs = 1'b1; id_rd_rt = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: id_rd_rs = 1'b1;
            default: ;
        endcase
        // Writes to R0 are dropped, so they never create hazards or forward.
        if (id_dest == 5'd0) id_wr = 1'b0;
    end

    // Write-through: a register written in WB this cycle reads as the new value.
    assign wb_hit = memwb_v && memwb_wr;

    always_comb begin
        id_a = Reg[id_rs];
        id_b = Reg[id_rt];
        if (wb_hit && memwb_dest == id_rs) id_a = memwb_res;
        if (wb_hit && memwb_dest == id_rt) id_b = memwb_res;
        if (id_rs == 5'd0) id_a = '0;
        if (id_rt == 5'd0) id_b = '0;
    end

    assign hit_ex  = idex_v && idex_wr &&
                     ((id_rd_rs && idex_dest == id_rs) || (id_rd_rt && idex_dest == id_rt));
    assign hit_mem = exmem_v && exmem_wr &&
                     ((id_rd_rs && exmem_dest == id_rs) || (id_rd_rt && exmem_dest == id_rt));

    // With forwarding only a load result is late; without it any in-flight
    // producer in EX or MEM blocks ID until it reaches WB.
    assign stall = ifid_v && ((FORWARD_EN != 0) ? (hit_ex && idex_op == OP_LW)
                                                : (hit_ex || hit_mem));

    // ---------------- EX: forwarding, ALU, branch resolution ----------------
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm, ex_res;
    logic [31:0]       ex_target;
    logic              ex_taken;

    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        if (FORWARD_EN != 0) begin
            if (exmem_v && exmem_wr && exmem_dest == idex_rs)      ex_a = exmem_res;
            else if (memwb_v && memwb_wr && memwb_dest == idex_rs) ex_a = memwb_res;
            if (exmem_v && exmem_wr && exmem_dest == idex_rt)      ex_b = exmem_res;
            else if (memwb_v && memwb_wr && memwb_dest == idex_rt) ex_b = memwb_res;
        end
    end

    assign ex_imm    = DATA_W'($signed(idex_imm));
    assign ex_target = idex_pc + 32'd1 + 32'($signed(idex_imm));
    assign ex_taken  = idex_v && (((idex_op == OP_BNEQZ) && (ex_a != '0)) ||
                                  ((idex_op == OP_BEQZ)  && (ex_a == '0)));

    always_comb begin
        ex_res = '0;
        case (idex_op)
            OP_ADD:               ex_res = ex_a + ex_b;
            OP_SUB:               ex_res = ex_a - ex_b;
            OP_AND:               ex_res = ex_a & ex_b;
            OP_OR:                ex_res = ex_a | ex_b;
            OP_SLT:               ex_res = DATA_W'($signed(ex_a) < $signed(ex_b));
            OP_MUL:               ex_res = ex_a * ex_b;
            OP_LW, OP_SW, OP_ADDI: ex_res = ex_a + ex_imm;
            OP_SUBI:              ex_res = ex_a - ex_imm;
            OP_SLTI:              ex_res = DATA_W'($signed(ex_a) < $signed(ex_imm));
            default:              ex_res = '0;
        endcase
    end

    // ---------------- MEM / IF memory ports ----------------
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_rdata, mem_result;
    logic [31:0]       if_ir;

    assign mem_addr   = exmem_res[AW-1:0];
    assign mem_rdata  = Mem[mem_addr][DATA_W-1:0];
    assign mem_result = (exmem_op == OP_LW) ? mem_rdata : exmem_res;
    assign if_ir      = Mem[pc_out[AW-1:0]][31:0];

    assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : Reg[dbg_raddr];

    // ---------------- pipeline state ----------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_out      <= '0;
            halted      <= 1'b0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
            fetch_stop  <= 1'b0;
            ifid_v      <= 1'b0;
            idex_v      <= 1'b0;
            exmem_v     <= 1'b0;
            memwb_v     <= 1'b0;
        end else if (!halted) begin
            // Flush beats stall; a held cycle is only counted when not flushed.
            if (ex_taken) begin
                pc_out <= ex_target;
                ifid_v <= 1'b0;
            end else if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else if (fetch_stop || id_hlt) begin
                ifid_v     <= 1'b0;
                fetch_stop <= 1'b1;
            end else begin
                ifid_v  <= 1'b1;
                ifid_ir <= if_ir;
                ifid_pc <= pc_out;
                pc_out  <= pc_out + 32'd1;
            end

            idex_v    <= ifid_v && !ex_taken && !stall;
            idex_op   <= id_op;
            idex_rs   <= id_rs;
            idex_rt   <= id_rt;
            idex_dest <= id_dest;
            idex_wr   <= id_wr;
            idex_a    <= id_a;
            idex_b    <= id_b;
            idex_imm  <= ifid_ir[15:0];
            idex_pc   <= ifid_pc;

            exmem_v     <= idex_v;
            exmem_op    <= idex_op;
            exmem_dest  <= idex_dest;
            exmem_wr    <= idex_wr;
            exmem_res   <= ex_res;
            exmem_sdata <= ex_b;

            memwb_v    <= exmem_v;
            memwb_op   <= exmem_op;
            memwb_dest <= exmem_dest;
            memwb_wr   <= exmem_wr;
            memwb_res  <= mem_result;

            if (memwb_v) begin
                retired_cnt <= retired_cnt + 32'd1;
                if (memwb_op == OP_HLT) halted <= 1'b1;
            end
        end
    end

    // Architectural storage: no reset, writes suppressed during reset and once halted.
    always_ff @(posedge clk1) begin
        if (!rst && !halted && memwb_v && memwb_wr)
            Reg[memwb_dest] <= memwb_res;
        if (!rst && !halted && exmem_v && exmem_op == OP_SW)
            Mem[mem_addr] <= MEM_W'(exmem_sdata);
    end

endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// tb_pipe_mips32_fwd
//   Runs directed and randomized programs on two copies of the core, one with
//   forwarding and one interlock-only, and checks them against an
//   instruction-level interpreter of the ISA.
module tb_pipe_mips32_fwd;
    localparam logic [5:0] OP_ADD  = 6'h00, OP_LW = 6'h08, OP_SW = 6'h09, OP_ADDI = 6'h0A,
                           OP_SUBI = 6'h0B, OP_SLTI = 6'h0C, OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E,
                           OP_HLT  = 6'h3F, OP_NOP = 6'h20;

    // ---------------- clock / reset ----------------
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;
    logic        rst;
    logic [4:0]  dbg_raddr;

    logic        f_halted, i_halted;
    logic [31:0] f_pc, i_pc, f_ret, i_ret, f_stall, i_stall, f_dbg, i_dbg;

    pipe_mips32_fwd #(.DATA_W(32), .MEM_DEPTH(1024), .FORWARD_EN(1)) dut_f (
        .clk1(clk1), .rst(rst), .halted(f_halted), .pc_out(f_pc), .retired_cnt(f_ret),
        .stall_cnt(f_stall), .dbg_raddr(dbg_raddr), .dbg_rdata(f_dbg));

    pipe_mips32_fwd #(.DATA_W(32), .MEM_DEPTH(1024), .FORWARD_EN(0)) dut_i (
        .clk1(clk1), .rst(rst), .halted(i_halted), .pc_out(i_pc), .retired_cnt(i_ret),
        .stall_cnt(i_stall), .dbg_raddr(dbg_raddr), .dbg_rdata(i_dbg));

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- program image and reference model ----------------
    logic [31:0] p_mem [1024];
    logic [31:0] p_reg [32];
    logic [31:0] m_mem [1024];
    logic [31:0] m_reg [32];
    int          m_ret, m_hpc;

    function automatic logic [31:0] rtype(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_image();
        for (int k = 0; k < 1024; k++) p_mem[k] = '0;
        for (int k = 0; k < 32; k++) p_reg[k] = '0;
    endtask

    task automatic wreg(input int d, input logic [31:0] v);
        if (d != 0) m_reg[d] = v;
    endtask

    // Sequential ISA interpreter: one instruction at a time, no pipeline.
    task automatic model_run(output int ret, output int hpc);
        logic [31:0] pc, ir, a, b, imm, addr;
        logic [5:0]  op;
        int          rs, rt, rd;
        bit          done;
        for (int k = 0; k < 32; k++) m_reg[k] = p_reg[k];
        for (int k = 0; k < 1024; k++) m_mem[k] = p_mem[k];
        pc = 0; ret = 0; hpc = 0; done = 0;
        for (int step = 0; step < 4000 && !done; step++) begin
            ir  = m_mem[pc[9:0]];
            op  = ir[31:26];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            a   = (rs == 0) ? 32'd0 : m_reg[rs];
            b   = (rt == 0) ? 32'd0 : m_reg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            addr = a + imm;
            ret++;
            case (op)
                6'h00: wreg(rd, a + b);
                6'h01: wreg(rd, a - b);
                6'h02: wreg(rd, a & b);
                6'h03: wreg(rd, a | b);
                6'h04: wreg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h05: wreg(rd, a * b);
                6'h08: wreg(rt, m_mem[addr[9:0]]);
                6'h09: m_mem[addr[9:0]] = b;
                6'h0A: wreg(rt, a + imm);
                6'h0B: wreg(rt, a - imm);
                6'h0C: wreg(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            if (op == 6'h3F) begin
                hpc  = int'(pc);
                done = 1;
            end else if ((op == 6'h0D && a != 0) || (op == 6'h0E && a == 0)) begin
                pc = pc + 32'd1 + imm;
            end else begin
                pc = pc + 32'd1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Reset both cores for one edge, check the reset state, optionally load images.
    task automatic reset_core(input string tag, input bit load);
        @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        check({tag, " f pc_out rst"},  f_pc, 32'd0);
        check({tag, " f retired rst"}, f_ret, 32'd0);
        check({tag, " f stall rst"},   f_stall, 32'd0);
        check({tag, " f halted rst"},  {31'd0, f_halted}, 32'd0);
        check({tag, " i pc_out rst"},  i_pc, 32'd0);
        check({tag, " i retired rst"}, i_ret, 32'd0);
        check({tag, " i halted rst"},  {31'd0, i_halted}, 32'd0);
        if (load) begin
            for (int k = 0; k < 1024; k++) begin
                dut_f.Mem[k] = p_mem[k];
                dut_i.Mem[k] = p_mem[k];
            end
            for (int k = 0; k < 32; k++) begin
                dut_f.Reg[k] = p_reg[k];
                dut_i.Reg[k] = p_reg[k];
            end
        end
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!(f_halted && i_halted) && n < budget) begin
            @(posedge clk1);
            #1;
            n++;
        end
    endtask

    // Compare both cores against the model: flags, counters, R1..R7, a Mem window.
    task automatic compare_model(input string tag, input int ret, input int hpc, input int base);
        check({tag, " f halted"}, {31'd0, f_halted}, 32'd1);
        check({tag, " i halted"}, {31'd0, i_halted}, 32'd1);
        check({tag, " f retired"}, f_ret, 32'(ret));
        check({tag, " i retired"}, i_ret, 32'(ret));
        check({tag, " f pc_out"}, f_pc, 32'(hpc + 1));
        check({tag, " i pc_out"}, i_pc, 32'(hpc + 1));
        for (int r = 1; r < 8; r++) begin
            dbg_raddr = 5'(r);
            #1;
            check($sformatf("%s f R%0d", tag, r), f_dbg, m_reg[r]);
            check($sformatf("%s i R%0d", tag, r), i_dbg, m_reg[r]);
        end
        for (int k = base; k < base + 16; k++) begin
            check($sformatf("%s f Mem[%0d]", tag, k), dut_f.Mem[k], m_mem[k]);
            check($sformatf("%s i Mem[%0d]", tag, k), dut_i.Mem[k], m_mem[k]);
        end
    endtask

    task automatic load_loop();
        clear_image();
        p_reg[4] = 32'h1234;
        p_reg[5] = 32'h77;
        p_mem[0] = itype(OP_ADDI, 1, 0, 3);
        p_mem[1] = itype(OP_SUBI, 1, 1, 1);
        p_mem[2] = itype(OP_BNEQZ, 0, 1, -2);
        p_mem[3] = itype(OP_ADDI, 5, 0, 7);
        p_mem[4] = {OP_HLT, 26'd0};
    endtask

    task automatic gen_random();
        int n, hlt_idx, sel, rs, rt, rd, mx, imm;
        clear_image();
        for (int k = 1; k < 7; k++)
            p_reg[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
        for (int k = 512; k < 528; k++) p_mem[k] = $urandom;
        n       = $urandom_range(12, 24);
        hlt_idx = n + 1;
        p_mem[0] = itype(OP_ADDI, 7, 0, 512);  // R7 is the data base, never rewritten
        for (int k = 1; k <= n; k++) begin
            sel = $urandom_range(0, 13);
            rs  = $urandom_range(0, 6);
            rt  = $urandom_range(0, 6);
            rd  = $urandom_range(0, 6);
            case (sel)
                0, 1, 2, 3, 4, 5: p_mem[k] = rtype(6'(sel), rd, rs, rt);
                6:  p_mem[k] = itype(OP_LW, rt, 7, $urandom_range(0, 15));
                7:  p_mem[k] = itype(OP_SW, rt, 7, $urandom_range(0, 15));
                8:  p_mem[k] = itype(OP_ADDI, rt, rs, $urandom_range(0, 200) - 100);
                9:  p_mem[k] = itype(OP_SUBI, rt, rs, $urandom_range(0, 200) - 100);
                10: p_mem[k] = itype(OP_SLTI, rt, rs, $urandom_range(0, 200) - 100);
                11, 12: begin
                    mx  = hlt_idx - k - 1;
                    imm = $urandom_range(0, (mx > 3) ? 3 : mx);
                    p_mem[k] = itype((sel == 11) ? OP_BNEQZ : OP_BEQZ, 0, rs, imm);
                end
                default: p_mem[k] = rtype(OP_NOP, rd, rs, rt);
            endcase
        end
        p_mem[hlt_idx]     = {OP_HLT, 26'd0};
        p_mem[hlt_idx + 1] = itype(OP_ADDI, 6, 0, 9);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        dbg_raddr = '0;

        // Load, add, store with no dummy instructions.
        clear_image();
        p_mem[120] = 32'd85;
        p_mem[0] = itype(OP_ADDI, 1, 0, 120);
        p_mem[1] = itype(OP_LW, 2, 1, 0);
        p_mem[2] = itype(OP_ADDI, 2, 2, 45);
        p_mem[3] = itype(OP_SW, 2, 1, 1);
        p_mem[4] = {OP_HLT, 26'd0};
        model_run(m_ret, m_hpc);
        reset_core("ldst", 1'b1);
        wait_halt(500);
        compare_model("ldst", m_ret, m_hpc, 112);
        check("ldst Mem[121]", dut_f.Mem[121], 32'd130);
        check("ldst Mem[120]", dut_f.Mem[120], 32'd85);
        check("ldst f retired", f_ret, 32'd5);
        check("ldst f stall", f_stall, 32'd1);
        check("ldst i stall", i_stall, 32'd6);

        // Back-to-back ALU dependencies.
        clear_image();
        p_mem[0] = itype(OP_ADDI, 1, 0, 10);
        p_mem[1] = rtype(OP_ADD, 2, 1, 1);
        p_mem[2] = rtype(OP_ADD, 3, 2, 1);
        p_mem[3] = {OP_HLT, 26'd0};
        model_run(m_ret, m_hpc);
        reset_core("alu", 1'b1);
        wait_halt(500);
        compare_model("alu", m_ret, m_hpc, 512);
        dbg_raddr = 5'd3;
        #1;
        check("alu f R3", f_dbg, 32'd30);
        check("alu i R3", i_dbg, 32'd30);
        check("alu f stall", f_stall, 32'd0);
        check("alu i stall", i_stall, 32'd4);

        // Counted loop with a taken backward branch.
        load_loop();
        model_run(m_ret, m_hpc);
        reset_core("loop", 1'b1);
        wait_halt(500);
        compare_model("loop", m_ret, m_hpc, 512);
        dbg_raddr = 5'd5;
        #1;
        check("loop f R5", f_dbg, 32'd7);
        check("loop f stall", f_stall, 32'd0);
        check("loop i stall", i_stall, 32'd8);

        // Reset pulsed mid-loop without reloading: run restarts cleanly.
        load_loop();
        model_run(m_ret, m_hpc);
        reset_core("rstmid", 1'b1);
        repeat (8) @(posedge clk1);
        #1;
        reset_core("rstmid pulse", 1'b0);
        wait_halt(500);
        compare_model("rstmid", m_ret, m_hpc, 512);
        check("rstmid i stall", i_stall, 32'd8);

        // Instruction after HLT must not execute; pc_out holds once halted.
        clear_image();
        p_reg[6] = 32'h55;
        p_mem[0] = itype(OP_ADDI, 1, 0, 1);
        p_mem[1] = {OP_HLT, 26'd0};
        p_mem[2] = itype(OP_ADDI, 6, 0, 9);
        model_run(m_ret, m_hpc);
        reset_core("hlt", 1'b1);
        wait_halt(500);
        compare_model("hlt", m_ret, m_hpc, 512);
        repeat (5) @(posedge clk1);
        #1;
        dbg_raddr = 5'd6;
        #1;
        check("hlt f R6 kept", f_dbg, 32'h55);
        check("hlt f pc stable", f_pc, 32'd2);
        check("hlt f retired stable", f_ret, 32'd2);

        // R0 stays zero.
        clear_image();
        p_reg[7] = 32'd99;
        p_mem[0] = itype(OP_ADDI, 0, 0, 5);
        p_mem[1] = rtype(OP_ADD, 7, 0, 0);
        p_mem[2] = {OP_HLT, 26'd0};
        model_run(m_ret, m_hpc);
        reset_core("r0", 1'b1);
        wait_halt(500);
        compare_model("r0", m_ret, m_hpc, 512);
        dbg_raddr = 5'd7;
        #1;
        check("r0 f dbg R7", f_dbg, 32'd0);
        dbg_raddr = 5'd0;
        #1;
        check("r0 f dbg R0", f_dbg, 32'd0);
        check("r0 i dbg R0", i_dbg, 32'd0);

        // Randomized programs against the interpreter.
        for (int t = 0; t < 8; t++) begin
            gen_random();
            model_run(m_ret, m_hpc);
            reset_core($sformatf("rnd%0d", t), 1'b1);
            wait_halt(2000);
            compare_model($sformatf("rnd%0d", t), m_ret, m_hpc, 512);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
